// File: rtl/fountain_v1_pkg.sv
// Shared types and constants for the fountain_v1 packetizer.
// FOUNTAIN_PKT_CRC_EN adds the CRC-8 helper used for the packet trailer.
package fountain_v1_pkg;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int         HDR_LEN       = 6;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

    typedef struct packed {
        logic [7:0]  len;
        logic [7:0]  blk_id;
        logic [7:0]  seq;
        logic [15:0] seed;
    } desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_CRC
    } state_t;

`ifdef FOUNTAIN_PKT_CRC_EN
    // One byte of MSB-first CRC-8 (running value c, new byte d).
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ({r[6:0], 1'b0} ^ CRC8_POLY) : {r[6:0], 1'b0};
        return r;
    endfunction
`endif

endpackage

// File: rtl/fountain_v1_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; push and pop may coincide
// at either boundary.
module fountain_v1_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_wr, do_rd;

    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || rd_en);
    assign rd_data = mem[rd_ptr];
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/fountain_v1_packetizer.sv
// Frames the encoded byte stream into header + payload packets.
// Define FOUNTAIN_PKT_CRC_EN to append a CRC-8 trailer byte to each packet.
module fountain_v1_packetizer
    import fountain_v1_pkg::*;
#(
    parameter int         SYMS_PER_PKT = 32,
    parameter int         FIFO_DEPTH   = 64,
    parameter int         DESC_DEPTH   = 4,
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic [15:0] in_seed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [15:0] pkt_count
);

    localparam int DCW = $clog2(FIFO_DEPTH) + 1;
    localparam int QCW = $clog2(DESC_DEPTH) + 1;

    logic           data_full, data_empty, desc_full, desc_empty;
    logic [DCW-1:0] unused_data_count;
    logic [QCW-1:0] desc_count;
    logic [7:0]     data_rd;
    desc_t          desc_wr, desc_rd;
    logic           acc, close, data_pop, desc_pop;

    logic [7:0]     seg_len, blk_id, seq;
    logic [15:0]    seed_q, seed_cur;
    logic           blk_start;

    state_t         state;
    logic [7:0]     idx;
    logic [7:0]     hdr_b;
    logic           advance, eop_hs;
`ifdef FOUNTAIN_PKT_CRC_EN
    logic [7:0]     crc;
`endif

    // ---------------- write side: segmenter ----------------
    assign in_ready = !reset && !data_full && !desc_full;
    assign acc      = in_valid && in_ready;
    assign close    = acc && (in_last || seg_len == 8'(SYMS_PER_PKT - 1));
    assign seed_cur = blk_start ? in_seed : seed_q;
    assign desc_wr  = '{len: seg_len + 8'd1, blk_id: blk_id, seq: seq, seed: seed_cur};

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_len   <= '0;
            blk_id    <= '0;
            seq       <= '0;
            seed_q    <= '0;
            blk_start <= 1'b1;
        end else if (acc) begin
            if (blk_start) begin
                seed_q    <= in_seed;
                blk_start <= 1'b0;
            end
            if (in_last) begin
                seg_len   <= '0;
                seq       <= '0;
                blk_id    <= blk_id + 8'd1;
                blk_start <= 1'b1;
            end else if (close) begin
                seg_len <= '0;
                seq     <= seq + 8'd1;
            end else begin
                seg_len <= seg_len + 8'd1;
            end
        end
    end

    fountain_v1_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (acc),
        .wr_data (in_data),
        .rd_en   (data_pop),
        .rd_data (data_rd),
        .full    (data_full),
        .empty   (data_empty),
        .count   (unused_data_count)
    );

    fountain_v1_sync_fifo #(.WIDTH($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_desc_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (close),
        .wr_data (desc_wr),
        .rd_en   (desc_pop),
        .rd_data (desc_rd),
        .full    (desc_full),
        .empty   (desc_empty),
        .count   (desc_count)
    );

    // ---------------- read side: framer ----------------
    // The output register is free when empty or being consumed this cycle.
    assign advance  = !out_valid || out_ready;
    assign eop_hs   = out_valid && out_eop && out_ready;
    assign desc_pop = eop_hs;
    assign data_pop = advance && !(out_valid && out_eop) && (state == ST_PAY) && !data_empty;

    always_comb begin
        hdr_b = SYNC_BYTE;
        case (idx[2:0])
            3'd1:    hdr_b = desc_rd.blk_id;
            3'd2:    hdr_b = desc_rd.seq;
            3'd3:    hdr_b = desc_rd.len;
            3'd4:    hdr_b = desc_rd.seed[15:8];
            3'd5:    hdr_b = desc_rd.seed[7:0];
            default: hdr_b = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            pkt_count <= '0;
`ifdef FOUNTAIN_PKT_CRC_EN
            crc       <= '0;
`endif
        end else if (eop_hs) begin
            pkt_count <= pkt_count + 16'd1;
            out_eop   <= 1'b0;
            // Head descriptor retires now; a waiting one starts without a gap.
            if (desc_count > QCW'(1)) begin
                out_valid <= 1'b1;
                out_data  <= SYNC_BYTE;
                out_sop   <= 1'b1;
                state     <= ST_HDR;
                idx       <= 8'd1;
`ifdef FOUNTAIN_PKT_CRC_EN
                crc       <= crc8(8'h00, SYNC_BYTE);
`endif
            end else begin
                out_valid <= 1'b0;
                out_sop   <= 1'b0;
                state     <= ST_IDLE;
                idx       <= '0;
            end
        end else if (advance) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!desc_empty) begin
                        state <= ST_HDR;
                        idx   <= '0;
                    end
                end
                ST_HDR: begin
                    out_valid <= 1'b1;
                    out_data  <= hdr_b;
                    out_sop   <= (idx == 8'd0);
`ifdef FOUNTAIN_PKT_CRC_EN
                    crc       <= crc8((idx == 8'd0) ? 8'h00 : crc, hdr_b);
`endif
                    if (idx == 8'(HDR_LEN - 1)) begin
                        state <= ST_PAY;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                ST_PAY: begin
                    out_valid <= 1'b1;
                    out_data  <= data_rd;
`ifdef FOUNTAIN_PKT_CRC_EN
                    crc       <= crc8(crc, data_rd);
`endif
                    if (idx == desc_rd.len - 8'd1) begin
                        idx <= '0;
`ifdef FOUNTAIN_PKT_CRC_EN
                        state <= ST_CRC;
`else
                        out_eop <= 1'b1;
                        state   <= ST_IDLE;
`endif
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
`ifdef FOUNTAIN_PKT_CRC_EN
                ST_CRC: begin
                    out_valid <= 1'b1;
                    out_data  <= crc;
                    out_eop   <= 1'b1;
                    state     <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fountain_v1_packetizer.md
Name: fountain_v1_packetizer

Overview:
Downstream stage of the serial fountain encoder: accepts the encoded byte stream, buffers it and frames it into packets for the link interface. Each packet is a fixed 6-byte header (sync, block id, sequence, length, 16-bit seed) followed by up to SYMS_PER_PKT payload bytes. Valid/ready handshakes on both sides; backpressure on the output propagates to the encoder through in_ready.

Parameters:
SYMS_PER_PKT, 32, max payload bytes per packet (1..255)
FIFO_DEPTH, 64, payload byte FIFO depth (power of 2, >= SYMS_PER_PKT)
DESC_DEPTH, 4, packet descriptor FIFO depth (power of 2)
SYNC_BYTE, 8'hA5, header byte 0

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  encoded byte present
in_ready  out  1  packetizer can accept
in_data  in  8  encoded byte
in_last  in  1  marks final byte of the current encoded block
in_seed  in  16  generator seed of current block; sampled with first accepted byte of a block
out_valid  out  1  output byte present
out_ready  in  1  sink accepts
out_data  out  8  framed byte
out_sop  out  1  high with header byte 0
out_eop  out  1  high with final byte of packet
pkt_count  out  16  packets fully sent, wraps at 16'hFFFF

Behaviour:
- Reset: in_ready=0 during reset, 1 the cycle after; out_valid/out_sop/out_eop=0; out_data=0; pkt_count=0; FIFOs empty; blk_id=0; seq=0; FSM=IDLE.
- Input accepted when in_valid&&in_ready. in_ready = !data_full && !desc_full.
- Write-side segmenter: seg_len counts accepted bytes. Segment closes on the byte where seg_len reaches SYMS_PER_PKT or in_last=1 (both same cycle -> one close). On close push descriptor {len, blk_id, seq, seed} in the same cycle as the byte write; seg_len->0.
- seed latched on first byte of each block (after reset or after an in_last byte). seq increments per descriptor, reset to 0 after in_last. blk_id increments after in_last, 8-bit wrap 255->0.
- Read FSM: IDLE -> HDR when descriptor FIFO non-empty (payload guaranteed present). HDR sends 6 bytes: SYNC_BYTE, blk_id, seq, len, seed[15:8], seed[7:0]. PAY sends len bytes popped from data FIFO. Then CRC (feature only) or back to IDLE; descriptor popped on final byte handshake. Back-to-back packets: from last byte, go directly to HDR if another descriptor waits (no idle cycle).
- Output is registered; out_data/out_sop/out_eop held stable while out_valid && !out_ready. Byte advances only on handshake.
- pkt_count increments on handshake of the eop byte.
- Simultaneous FIFO push and pop permitted at full and empty boundaries; count unchanged when both occur.
- Reset mid-packet: packet abandoned, no eop emitted, all buffered data discarded.
- Latency: first byte of a closed segment appears at out_data 2 cycles after its closing input handshake when idle.

Optional Feature:
FOUNTAIN_PKT_CRC_EN: when defined, a CRC-8 byte (poly 0x07, init 0x00, MSB-first, over header and payload) is appended after payload and carries out_eop; without it, out_eop is on the last payload byte and no CRC logic exists.

Decomposition:
- Package fountain_v1_pkg: SYNC_BYTE, HDR_LEN=6, CRC8_POLY, descriptor struct typedef (len, blk_id, seq, seed), read FSM state enum.
- One sub-module: fountain_v1_sync_fifo (parameterised width/depth, full/empty/count), instanced twice (data 8-bit, descriptor 40-bit).

Test Plan:
- 32 bytes 0x00..0x1F, in_last on last, seed 0x1234, out_ready=1 -> A5 00 00 20 12 34 00..1F, sop on A5, eop on 1F, pkt_count=1.
- 70 bytes, in_last on byte 70 -> three packets len 0x20,0x20,0x06, seq 0,1,2, all blk_id 0.
- Two blocks of 5 bytes (seeds 0xAAAA, 0x5555) -> headers A5 00 00 05 AA AA and A5 01 00 05 55 55, no idle cycle between packets.
- out_ready toggled random 50% with continuous input -> output byte sequence identical to out_ready=1 run, data stable while stalled, in_ready drops when FIFO holds 64 bytes.
- 256 one-byte blocks -> blk_id wraps 0xFF->0x00; reset asserted mid-payload -> out_valid=0 next cycle, pkt_count=0, next packet starts at blk_id 0.
- With FOUNTAIN_PKT_CRC_EN, single-byte block 0x00 seed 0x0000 -> 8 bytes, final byte = CRC-8 of A5 00 00 01 00 00 00 carrying eop.
